// File: rtl/complex_accumulator.sv
// Complex dot-product accumulate stage.
// Sums ACC_LEN consecutive packed complex products, saturates the block sum
// back to the product format and presents it on a valid/ready output.
module complex_accumulator #(
  parameter int INTEGER_WIDTH    = 8,
  parameter int FRACTIONAL_WIDTH = 8,
  parameter int ACC_LEN          = 16
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             s_prod_tvalid,
  output logic                                             s_prod_tready,
  input  logic [2*(INTEGER_WIDTH+FRACTIONAL_WIDTH)-1:0]    s_prod_tdata,
  output logic                                             m_acc_tvalid,
  input  logic                                             m_acc_tready,
  output logic [2*(INTEGER_WIDTH+FRACTIONAL_WIDTH)-1:0]    m_acc_tdata,
  output logic                                             m_acc_tsat
);

  localparam int W = INTEGER_WIDTH + FRACTIONAL_WIDTH;
  localparam int G = $clog2(ACC_LEN);
  localparam logic [G-1:0] LAST = G'(ACC_LEN - 1);

  logic [W+G-1:0] acc_re, acc_im;
  logic [W+G-1:0] sum_re, sum_im;
  logic [W-1:0]   beat_re, beat_im;
  logic [G-1:0]   cnt;
  logic [W:0]     sat_re, sat_im;
  logic           last, accept, take;

  // Clip a wide sum to W bits; bit W of the result flags that clipping happened.
  // The value is in range when all bits from the sign down to bit W-1 agree.
  function automatic logic [W:0] saturate(input logic [W+G-1:0] v);
    if (v[W+G-1:W-1] == '0 || v[W+G-1:W-1] == '1)
      return {1'b0, v[W-1:0]};
    else if (v[W+G-1])
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  assign beat_re = s_prod_tdata[2*W-1:W];
  assign beat_im = s_prod_tdata[W-1:0];
  assign last    = (cnt == LAST);
  assign take    = m_acc_tvalid && m_acc_tready;

  // Only the closing beat of a block can stall, and only while it would
  // overwrite a result the consumer has not taken yet.
  assign s_prod_tready = !(m_acc_tvalid && !m_acc_tready && last);
  assign accept        = s_prod_tvalid && s_prod_tready;

  // Running sum including the current beat, plus its saturated form.
  always_comb begin
    sum_re = acc_re + {{G{beat_re[W-1]}}, beat_re};
    sum_im = acc_im + {{G{beat_im[W-1]}}, beat_im};
    sat_re = saturate(sum_re);
    sat_im = saturate(sum_im);
  end

  // Accumulator and beat counter; both clear on the edge that closes a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re <= '0;
      acc_im <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (last) begin
        acc_re <= '0;
        acc_im <= '0;
        cnt    <= '0;
      end else begin
        acc_re <= sum_re;
        acc_im <= sum_im;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  // Output register: loads on a closing beat (even while the old result is
  // being taken, giving back-to-back output), otherwise holds until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc_tvalid <= 1'b0;
      m_acc_tdata  <= '0;
      m_acc_tsat   <= 1'b0;
    end else if (accept && last) begin
      m_acc_tvalid <= 1'b1;
      m_acc_tdata  <= {sat_re[W-1:0], sat_im[W-1:0]};
      m_acc_tsat   <= sat_re[W] | sat_im[W];
    end else if (take) begin
      m_acc_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_accumulator.sv
// Scoreboard bench for complex_accumulator with ACC_LEN=4, Q8.8 components.
module tb_complex_accumulator;

  localparam int ACC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_prod_tvalid = 1'b0;
  logic        s_prod_tready;
  logic [31:0] s_prod_tdata = '0;
  logic        m_acc_tvalid;
  logic        m_acc_tready = 1'b1;
  logic [31:0] m_acc_tdata;
  logic        m_acc_tsat;

  complex_accumulator #(
    .INTEGER_WIDTH(8),
    .FRACTIONAL_WIDTH(8),
    .ACC_LEN(ACC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_prod_tvalid(s_prod_tvalid),
    .s_prod_tready(s_prod_tready),
    .s_prod_tdata(s_prod_tdata),
    .m_acc_tvalid(m_acc_tvalid),
    .m_acc_tready(m_acc_tready),
    .m_acc_tdata(m_acc_tdata),
    .m_acc_tsat(m_acc_tsat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          pres_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          nbeat = 0;
  bit          no_stall = 0;
  logic [31:0] next_data;
  logic        next_sat;
  bit          prev_valid = 0;
  bit          prev_taken = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_acc_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h with no result expected (cycle %0d)", m_acc_tdata, cyc);
        end else begin
          if (!prev_valid || prev_taken) begin
            chk("latency", 64'(cyc), 64'(exp_q[0].due));
            pres_q.push_back(cyc);
          end
          chk("data", 64'(m_acc_tdata), 64'(exp_q[0].data));
          chk("sat", 64'(m_acc_tsat), 64'(exp_q[0].sat));
          if (m_acc_tready) void'(exp_q.pop_front());
        end
      end
      prev_valid = m_acc_tvalid;
      prev_taken = m_acc_tvalid && m_acc_tready;
    end else begin
      prev_valid = 0;
      prev_taken = 0;
    end
  end

  // Wait for the offered beat to be taken; closing beats queue the expected result.
  task automatic wait_accept();
    bit ok = 0;
    int waited = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_prod_tready) begin
        ok = 1;
        waited = i;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %h never accepted", s_prod_tdata);
    end else begin
      if (no_stall && waited != 0) begin
        checks++;
        errors++;
        $display("FAIL ready_drop: stalled %0d cycles, required 0", waited);
      end
      if (nbeat == ACC - 1) begin
        exp_t e;
        e.data = next_data;
        e.sat  = next_sat;
        e.due  = cyc + 1;
        exp_q.push_back(e);
      end
      nbeat = (nbeat + 1) % ACC;
    end
    @(posedge clk);
    #1;
    s_prod_tvalid = 1'b0;
    s_prod_tdata  = $urandom;
  endtask

  task automatic send_beat(input logic [31:0] d);
    s_prod_tvalid = 1'b1;
    s_prod_tdata  = d;
    wait_accept();
  endtask

  task automatic send_block(input logic [31:0] d, input logic [31:0] res, input logic sat);
    next_data = res;
    next_sat  = sat;
    for (int i = 0; i < ACC; i++) send_beat(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(m_acc_tvalid), 64'(0));
    chk({tag, "_tdata"}, 64'(m_acc_tdata), 64'(0));
    chk({tag, "_tsat"}, 64'(m_acc_tsat), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(s_prod_tready), 64'(1));
    @(posedge clk);
    #1;

    // Basic sum
    send_block(32'h0100_FF00, 32'h0400_FC00, 1'b0);
    idle(3);

    // Positive and negative saturation, then a clean block
    send_block(32'h7F00_8000, 32'h7FFF_8000, 1'b1);
    send_block(32'h0001_0001, 32'h0004_0004, 1'b0);
    idle(3);

    // Backpressure
    m_acc_tready = 1'b0;
    next_data = 32'h0400_0400;
    next_sat  = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(32'h0100_0100);
    s_prod_tvalid = 1'b1;
    s_prod_tdata  = 32'h0100_0100;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 64'(s_prod_tready), 64'(0));
      chk("held_valid", 64'(m_acc_tvalid), 64'(1));
    end
    @(posedge clk);
    #1;
    m_acc_tready = 1'b1;
    wait_accept();
    idle(3);

    // Throughput: three blocks of continuous beats
    pres_q.delete();
    no_stall = 1;
    for (int b = 0; b < 3; b++) send_block(32'h0010_FFF0, 32'h0040_FFC0, 1'b0);
    no_stall = 0;
    idle(3);
    chk("tput_count", 64'(pres_q.size()), 64'(3));
    if (pres_q.size() == 3) begin
      chk("tput_gap1", 64'(pres_q[1] - pres_q[0]), 64'(ACC));
      chk("tput_gap2", 64'(pres_q[2] - pres_q[1]), 64'(ACC));
    end

    // Reset mid-block
    next_data = 32'h0;
    next_sat  = 1'b0;
    send_beat(32'h0200_0200);
    send_beat(32'h0200_0200);
    rst_n = 1'b0;
    nbeat = 0;
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("mid_rst");
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_block(32'h0100_0000, 32'h0400_0000, 1'b0);
    idle(3);

    // Gapped input
    next_data = 32'h0200_FE00;
    next_sat  = 1'b0;
    for (int i = 0; i < ACC; i++) begin
      idle($urandom_range(0, 3));
      send_beat(32'h0080_FF80);
    end
    idle(5);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_accumulator.md
Name: complex_accumulator

Overview:
- Downstream consumer of the complex multiplier's product stream.
- Sums every ACC_LEN consecutive complex products into one complex result. This is a dot-product / correlation accumulate stage.
- Saturates each result back to the product format and emits it on an AXI-Stream-style valid/ready output.
- Both sides use the same packed complex fixed-point word as the multiplier: real part in the upper half, imaginary part in the lower half.

Parameters:
- INTEGER_WIDTH, 8, integer bits per component (incl. sign), matches multiplier
- FRACTIONAL_WIDTH, 8, fractional bits per component, matches multiplier
- ACC_LEN, 16, products summed per output result; integer >= 2

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- s_prod_tvalid  input  1  product beat valid
- s_prod_tready  output  1  accumulator can accept a beat
- s_prod_tdata  input  2*(INTEGER_WIDTH+FRACTIONAL_WIDTH)  [2W-1:W] real, [W-1:0] imag; signed two's complement Q(INTEGER_WIDTH.FRACTIONAL_WIDTH)
- m_acc_tvalid  output  1  accumulated result valid
- m_acc_tready  input  1  downstream accepts result
- m_acc_tdata  output  2*(INTEGER_WIDTH+FRACTIONAL_WIDTH)  saturated sum, same packing/format as input
- m_acc_tsat  output  1  at least one component of this result was clipped

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Definitions: W = INTEGER_WIDTH + FRACTIONAL_WIDTH; G = clog2(ACC_LEN).
- Accumulator width: acc_re and acc_im are W+G bits each, signed. The internal sum never overflows.
- Beat counter: cnt, clog2(ACC_LEN) bits.
- Handshake: a beat is accepted when s_prod_tvalid && s_prod_tready; a result is taken when m_acc_tvalid && m_acc_tready.
- On an accepted beat with cnt < ACC_LEN-1:
  - acc_re += sext(real), acc_im += sext(imag);
  - cnt++.
- On an accepted beat with cnt == ACC_LEN-1 (last beat):
  - final sum = acc + beat;
  - each component is saturated to [-2^(W-1), 2^(W-1)-1] and written to the output register;
  - m_acc_tsat = OR of both clip flags;
  - m_acc_tvalid is set, registered: it asserts in the cycle after the last beat.
  - acc_re, acc_im and cnt clear to 0 in the same edge.
- Latency: result valid exactly 1 cycle after the last accepted beat of a block.
- Output register:
  - holds m_acc_tdata and m_acc_tsat stable while m_acc_tvalid && !m_acc_tready;
  - m_acc_tvalid clears on a taken result unless a new result loads in the same edge. In that case it stays 1 with the new data (back-to-back).
- Ready rule (combinational): s_prod_tready = !(m_acc_tvalid && !m_acc_tready && cnt == ACC_LEN-1).
  - Non-last beats are always accepted, even while a result is pending.
  - Only the beat that would overwrite an unconsumed result is stalled.
  - s_prod_tready does not depend on s_prod_tvalid.
- Saturation: a positive clip gives 0x7F..F; a negative clip gives 0x80..0. Clipping is per component, independent for real and imag.
- Reset values:
  - s_prod_tready = 1 (after reset release);
  - m_acc_tvalid = 0, m_acc_tdata = 0, m_acc_tsat = 0;
  - acc = 0, cnt = 0.
- Reset mid-block: partial sums and cnt are discarded, and any pending result is dropped. The first beat after reset starts a new block.
- Rule: s_prod_tdata is ignored when s_prod_tvalid = 0. Any value during stall cycles has no effect.

Test Plan (INTEGER_WIDTH=8, FRACTIONAL_WIDTH=8, ACC_LEN=4, W=16):
- Basic sum:
  - Stimulus: 4 beats of 0x0100_FF00 (+1.0, -1.0), m_acc_tready=1.
  - Response: m_acc_tdata=0x0400_FC00 and m_acc_tsat=0, valid for 1 cycle, 1 cycle after the 4th beat.
- Positive and negative saturation:
  - Stimulus: 4 beats of 0x7F00_8000.
  - Response: m_acc_tdata=0x7FFF_8000, m_acc_tsat=1.
  - Then 4 beats of 0x0001_0001 -> 0x0004_0004, m_acc_tsat=0. This confirms the accumulator was cleared.
- Backpressure:
  - Stimulus: m_acc_tready=0, 8 beats of 0x0100_0100 offered continuously.
  - Response: first result 0x0400_0400 held stable; beats 5-7 accepted; s_prod_tready=0 on beat 8.
  - Then raise m_acc_tready: beat 8 accepted in the same cycle, and the second result 0x0400_0400 follows next cycle.
- Throughput: continuous valid beats and m_acc_tready=1 for 3 blocks -> s_prod_tready never drops, and m_acc_tvalid pulses exactly every 4 cycles.
- Reset mid-block:
  - Stimulus: 2 beats of 0x0200_0200, assert rst_n=0 for 2 cycles, then 4 beats of 0x0100_0000.
  - Response: outputs are 0 during reset; the single result is 0x0400_0000.
- Gapped input: 4 beats of 0x0080_FF80 with random tvalid gaps -> result 0x0200_FE00, exactly 1 cycle after the last accepted beat.
